regfile_read_arbiter: RTL and testbench

REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

---
 rtl/regfile_read_arbiter_pkg.sv | 13 +
 rtl/regfile_read_arbiter_rr_pick.sv | 38 +++
 rtl/regfile_read_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_read_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_read_arbiter_pkg.sv
// Shared types and default widths for the register-file read arbiter.
package regfile_read_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SIZE  = 5;

endpackage

// File: rtl/regfile_read_arbiter_rr_pick.sv
// Round-robin priority pick: first set req bit at or above ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win_onehot,
  output logic [IDW-1:0]  win_idx,
  output logic            win_valid
);

  int             pos;
  logic [IDW-1:0] pos_idx;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    pos        = 0;
    pos_idx    = '0;
    // Walk offsets from the farthest to the nearest so the nearest set bit wins last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      pos_idx = IDW'(pos);
      if (req[pos_idx]) begin
        win_onehot          = '0;
        win_onehot[pos_idx] = 1'b1;
        win_idx             = pos_idx;
        win_valid           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NREQ requesters.
// Optional macro REGARB_R0_ZERO_EN forces reads of address 0 to return zero.
module regfile_read_arbiter
  import regfile_read_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SIZE  = DEF_SIZE,
  parameter int NREQ  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*SIZE-1:0]     req_addr,
  output logic [NREQ-1:0]          gnt,
  output logic [SIZE-1:0]          port_addr,
  input  logic [WIDTH-1:0]         port_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(NREQ)-1:0]  rd_id
);

  localparam int IDW = $clog2(NREQ);

`ifdef REGARB_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [IDW-1:0]    rd_id_q, rd_id_d;
  logic [SIZE-1:0]   port_addr_q, port_addr_d;
  logic [SIZE-1:0]   addr_q, addr_d;
  logic [IDW-1:0]    id_q, id_d;

  logic [NREQ-1:0]   win_onehot;
  logic [IDW-1:0]    win_idx;
  logic              win_valid;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req        (req),
    .ptr        (ptr_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_valid  (win_valid)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    rd_id_d     = rd_id_q;
    port_addr_d = port_addr_q;
    addr_d      = addr_q;
    id_d        = id_q;

    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          gnt_d       = win_onehot;
          addr_d      = req_addr[int'(win_idx)*SIZE +: SIZE];
          port_addr_d = req_addr[int'(win_idx)*SIZE +: SIZE];
          id_d        = win_idx;
          ptr_d       = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          state_d     = READ;
        end
      end
      READ: begin
        // port_addr was registered on the grant edge, so port_data is settled here.
        rd_data_d  = (R0_ZERO && (addr_q == '0)) ? '0 : port_data;
        rd_id_d    = id_q;
        rd_valid_d = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        if (rd_ready) begin
          // Return response outputs to their idle values once accepted.
          rd_valid_d = 1'b0;
          rd_data_d  = '0;
          rd_id_d    = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_id_q     <= '0;
      port_addr_q <= '0;
      addr_q      <= '0;
      id_q        <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_id_q     <= rd_id_d;
      port_addr_q <= port_addr_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
    end
  end

  assign gnt       = gnt_q;
  assign port_addr = port_addr_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_id     = rd_id_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: vector table plus reset, fairness and backpressure sequences.
module tb_regfile_read_arbiter;

  localparam int WIDTH = 32;
  localparam int SIZE  = 5;
  localparam int NREQ  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*SIZE-1:0] req_addr;
  logic [NREQ-1:0]   gnt;
  logic [SIZE-1:0]   port_addr;
  logic [WIDTH-1:0]  port_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [WIDTH-1:0]  rd_data;
  logic [1:0]        rd_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_read_arbiter #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE),
    .NREQ  (NREQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .port_addr (port_addr),
    .port_data (port_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_id     (rd_id)
  );

  // Register file contents seen through the read-port mux.
  function automatic logic [31:0] rf_val(input logic [4:0] a);
    if (a == 5'd7)      return 32'hDEADBEEF;
    else if (a == 5'd0) return 32'hFFFFFFFF;
    else                return 32'hC0DE0000 | (32'(a) * 32'h111);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
`ifdef REGARB_R0_ZERO_EN
    if (a == 5'd0) return 32'h0;
`endif
    return rf_val(a);
  endfunction

  function automatic logic [19:0] pack(input logic [4:0] a0, input logic [4:0] a1,
                                       input logic [4:0] a2, input logic [4:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  assign port_data = rf_val(port_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [19:0] addrs;
    int          stall;
    logic [3:0]  exp_gnt;
    logic [1:0]  exp_id;
    logic [4:0]  exp_addr;
  } vec_t;

  // One full read: request, grant, response (optionally stalled), acceptance.
  task automatic run_txn(input vec_t v, input string tag);
    @(negedge clk);
    req      = v.req;
    req_addr = v.addrs;
    rd_ready = (v.stall == 0);
    @(posedge clk); #1;
    check({tag, " gnt"}, 32'(gnt), 32'(v.exp_gnt));
    check({tag, " port_addr"}, 32'(port_addr), 32'(v.exp_addr));
    check({tag, " rd_valid_early"}, 32'(rd_valid), 32'd0);
    @(negedge clk);
    req = 4'b1111;
    @(posedge clk); #1;
    check({tag, " gnt_pulse"}, 32'(gnt), 32'd0);
    check({tag, " rd_valid"}, 32'(rd_valid), 32'd1);
    check({tag, " rd_data"}, rd_data, exp_rd(v.exp_addr));
    check({tag, " rd_id"}, 32'(rd_id), 32'(v.exp_id));
    for (int i = 0; i < v.stall; i++) begin
      @(negedge clk);
      req = i[0] ? 4'b0000 : 4'b1111;
      @(posedge clk); #1;
      check({tag, " hold_valid"}, 32'(rd_valid), 32'd1);
      check({tag, " hold_data"}, rd_data, exp_rd(v.exp_addr));
      check({tag, " hold_id"}, 32'(rd_id), 32'(v.exp_id));
      check({tag, " hold_gnt"}, 32'(gnt), 32'd0);
    end
    @(negedge clk);
    rd_ready = 1'b1;
    req      = 4'b0000;
    @(posedge clk); #1;
    check({tag, " rd_valid_clear"}, 32'(rd_valid), 32'd0);
    check({tag, " gnt_idle"}, 32'(gnt), 32'd0);
    $display("%s: req=%b gnt=%b id=%0d data=%h stall=%0d", tag, v.req, v.exp_gnt, v.exp_id,
             exp_rd(v.exp_addr), v.stall);
  endtask

  vec_t vecs[7];

  initial begin
    int   nrise;
    int   last_cyc;
    logic prev_valid;

    // Expected grants follow the pointer: 0 -> 2 -> 3 -> 1 -> 3 -> 0 -> 1 -> 2.
    vecs[0] = '{4'b0010, pack(5'd0, 5'd7, 5'd0, 5'd0),   0, 4'b0010, 2'd1, 5'd7};
    vecs[1] = '{4'b0101, pack(5'd3, 5'd0, 5'd12, 5'd0),  0, 4'b0100, 2'd2, 5'd12};
    vecs[2] = '{4'b0101, pack(5'd3, 5'd0, 5'd12, 5'd0),  0, 4'b0001, 2'd0, 5'd3};
    vecs[3] = '{4'b0101, pack(5'd3, 5'd0, 5'd14, 5'd0),  0, 4'b0100, 2'd2, 5'd14};
    vecs[4] = '{4'b1000, pack(5'd1, 5'd2, 5'd3, 5'd31),  5, 4'b1000, 2'd3, 5'd31};
    vecs[5] = '{4'b0001, pack(5'd0, 5'd2, 5'd3, 5'd4),   0, 4'b0001, 2'd0, 5'd0};
    vecs[6] = '{4'b0011, pack(5'd5, 5'd9, 5'd3, 5'd4),   2, 4'b0010, 2'd1, 5'd9};

    rst      = 1'b1;
    req      = '0;
    req_addr = '0;
    rd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset gnt", 32'(gnt), 32'd0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset rd_data", rd_data, 32'd0);
    check("reset rd_id", 32'(rd_id), 32'd0);
    check("reset port_addr", 32'(port_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle gnt", 32'(gnt), 32'd0);
      check("idle rd_valid", 32'(rd_valid), 32'd0);
    end

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while the read is in flight: no response, pointer back to 0.
    @(negedge clk);
    req      = 4'b0100;
    req_addr = pack(5'd1, 5'd2, 5'd12, 5'd4);
    @(posedge clk); #1;
    check("midrst gnt", 32'(gnt), 32'h4);
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    @(posedge clk); #1;
    check("midrst gnt_clear", 32'(gnt), 32'd0);
    check("midrst rd_valid", 32'(rd_valid), 32'd0);
    check("midrst port_addr", 32'(port_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst no_resp", 32'(rd_valid), 32'd0);
    $display("midrst: reset in READ, response aborted");
    run_txn('{4'b1111, pack(5'd2, 5'd3, 5'd4, 5'd5), 0, 4'b0001, 2'd0, 5'd2}, "postrst_ptr0");
    run_txn('{4'b1000, pack(5'd2, 5'd3, 5'd4, 5'd20), 0, 4'b1000, 2'd3, 5'd20}, "postrst_req3");

    // Fairness: all requesters held, ids rotate, one response every 3 cycles.
    @(negedge clk);
    req      = 4'b1111;
    req_addr = pack(5'd1, 5'd2, 5'd3, 5'd4);
    rd_ready = 1'b1;
    nrise      = 0;
    last_cyc   = 0;
    prev_valid = 1'b0;
    for (int cyc = 0; cyc < 60 && nrise < 8; cyc++) begin
      @(posedge clk); #1;
      if (rd_valid && !prev_valid) begin
        check($sformatf("fair id%0d", nrise), 32'(rd_id), 32'(nrise % 4));
        check($sformatf("fair data%0d", nrise), rd_data, rf_val(5'((nrise % 4) + 1)));
        if (nrise > 0) begin
          check($sformatf("fair spacing%0d", nrise), 32'(cyc - last_cyc), 32'd3);
        end
        $display("fair txn %0d: rd_id=%0d rd_data=%h cycle=%0d", nrise, rd_id, rd_data, cyc);
        last_cyc = cyc;
        nrise++;
      end
      prev_valid = rd_valid;
    end
    check("fair count", 32'(nrise), 32'd8);
    @(negedge clk);
    req = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
